// File: rtl/alu_writeback.sv
// alu_writeback: writeback stage behind the 19-bit ALU.
// Takes a 38-bit ALU result plus opcode and destination register and drives
// registered register-file write ports. MUL results are written as two
// consecutive words (low half to rd, high half to rd+1). Undefined opcodes
// consume a slot, pulse illegal_op and never write.
//
// Build option: define ALU_WB_FLAGS_EN to build the Z/N/V status flag
// registers; with it undefined the flag outputs are constant 0.
//
// Handshake: a transfer happens on a rising clk edge where in_valid and
// in_ready are both 1. in_ready depends only on internal state, never on
// in_valid. in_* are sampled only on a transfer edge.
module alu_writeback #(
  parameter int DATA_W = 19,
  parameter int REG_AW = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*DATA_W-1:0] in_result,
  input  logic [4:0]          in_opcode,
  input  logic [REG_AW-1:0]   in_rd,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                flag_z,
  output logic                flag_n,
  output logic                flag_v,
  output logic                illegal_op,
  output logic [1:0]          dbg_state
);

  localparam logic [4:0] OP_MUL       = 5'b00010;
  localparam logic [4:0] OP_LEGAL_MAX = 5'b01001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                cap_mul;     // captured op is MUL: a high write is pending
  logic [REG_AW-1:0]   cap_rd;
  logic [DATA_W-1:0]   cap_hi;

  logic                xfer;
  logic                in_legal;
  logic                in_mul;

  logic                rf_we_nxt;
  logic [REG_AW-1:0]   rf_waddr_nxt;
  logic [DATA_W-1:0]   rf_wdata_nxt;
  logic                illegal_nxt;

  assign dbg_state = state;
  assign in_legal  = (in_opcode <= OP_LEGAL_MAX);
  assign in_mul    = (in_opcode == OP_MUL);

  // Ready whenever no high write is still owed; held low during reset.
  assign in_ready = rst_n && ((state == IDLE) || (state == WR_HI) ||
                              (state == WR_LO && !cap_mul));
  assign xfer     = in_valid && in_ready;

  // Next state and next registered write-port values.
  always_comb begin
    state_nxt    = state;
    rf_we_nxt    = 1'b0;
    rf_waddr_nxt = rf_waddr;
    rf_wdata_nxt = rf_wdata;
    illegal_nxt  = 1'b0;
    case (state)
      IDLE:    if (xfer) state_nxt = WR_LO;
      WR_LO: begin
        if (cap_mul)   state_nxt = WR_HI;
        else if (xfer) state_nxt = WR_LO;
        else           state_nxt = IDLE;
      end
      WR_HI:   state_nxt = xfer ? WR_LO : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (xfer) begin
      // Low-half (or only) write slot for the newly accepted op.
      if (in_legal) begin
        rf_we_nxt    = 1'b1;
        rf_waddr_nxt = in_rd;
        rf_wdata_nxt = in_result[DATA_W-1:0];
      end else begin
        illegal_nxt  = 1'b1;
      end
    end else if (state == WR_LO && cap_mul) begin
      // High-half write of a MUL; address wraps modulo the register count.
      rf_we_nxt    = 1'b1;
      rf_waddr_nxt = cap_rd + 1'b1;
      rf_wdata_nxt = cap_hi;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture of the pending MUL high half on each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_mul <= 1'b0;
      cap_rd  <= '0;
      cap_hi  <= '0;
    end else if (xfer) begin
      cap_mul <= in_mul;
      cap_rd  <= in_rd;
      cap_hi  <= in_result[2*DATA_W-1:DATA_W];
    end else if (state == WR_LO) begin
      cap_mul <= 1'b0;
    end
  end

  // Registered register-file write port and illegal-op pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      illegal_op <= 1'b0;
    end else begin
      rf_we      <= rf_we_nxt;
      rf_waddr   <= rf_waddr_nxt;
      rf_wdata   <= rf_wdata_nxt;
      illegal_op <= illegal_nxt;
    end
  end

`ifdef ALU_WB_FLAGS_EN
  logic flag_upd, z_nxt, n_nxt, v_nxt;

  // Flag values for a legal op, taken at its transfer (low-write) edge.
  always_comb begin
    flag_upd = xfer && in_legal;
    z_nxt    = 1'b0;
    n_nxt    = 1'b0;
    v_nxt    = 1'b0;
    if (in_mul) begin
      z_nxt = (in_result == '0);
      n_nxt = in_result[2*DATA_W-1];
      v_nxt = (in_result[2*DATA_W-1:DATA_W] != '0);
    end else begin
      z_nxt = (in_result[DATA_W-1:0] == '0);
      n_nxt = in_result[DATA_W-1];
      v_nxt = 1'b0;
    end
  end

  // Flag registers; they hold across illegal ops and idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_v <= 1'b0;
    end else if (flag_upd) begin
      flag_z <= z_nxt;
      flag_n <= n_nxt;
      flag_v <= v_nxt;
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
  assign flag_v = 1'b0;
`endif

endmodule

// File: doc/alu_writeback.md
# alu_writeback

Writeback stage directly downstream of the 19-bit ALU. Accepts the ALU's 38-bit result with its opcode and destination register, and drives registered register-file write ports. Multiply results are split into two consecutive 19-bit writes, low half first. Also maintains the status flags and rejects undefined opcodes without writing.

## Interface
- `DATA_W`, 19, register/data word width; the result bus is 2*DATA_W.
- `REG_AW`, 3, register-file address width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ALU result on `in_*` is valid.
- `in_ready`  out  1  stage can accept this cycle.
- `in_result`  in  2*DATA_W  ALU output bus.
- `in_opcode`  in  5  opcode that produced `in_result`.
- `in_rd`  in  REG_AW  destination register.
- `rf_we`  out  1  register-file write enable, registered.
- `rf_waddr`  out  REG_AW  write address, registered.
- `rf_wdata`  out  DATA_W  write data, registered.
- `flag_z`  out  1  zero flag.
- `flag_n`  out  1  negative flag, the MSB of the result.
- `flag_v`  out  1  multiply high half nonzero.
- `illegal_op`  out  1  one-cycle pulse when an undefined opcode is accepted.

## Operation
- A transfer occurs when `in_valid && in_ready`.
- State machine, IDLE/WR_LO/WR_HI:
  - IDLE: a transfer moves to WR_LO.
  - WR_LO: if the captured op is MUL (5'b00010), go to WR_HI. Otherwise, a transfer in the same cycle stays in WR_LO; no transfer returns to IDLE.
  - WR_HI: a transfer goes to WR_LO; else go to IDLE.
- `in_ready` = (state==IDLE) || (state==WR_HI) || (state==WR_LO && captured op != MUL). `in_ready` is 0 while reset is asserted.
- Write in WR_LO: `rf_we`=1, `rf_waddr`=rd, `rf_wdata`=`in_result[DATA_W-1:0]`.
- Write in WR_HI: `rf_we`=1, `rf_waddr`=(rd+1) mod 2^REG_AW (wraps 7→0), `rf_wdata`=`in_result[2*DATA_W-1:DATA_W]`.
- Legal opcodes are 5'b00000–5'b01001. For any other accepted opcode:
  - `rf_we` stays 0 and the flags are unchanged.
  - `illegal_op` pulses for one cycle, in the slot where the write would occur.
  - The slot is consumed like a non-MUL op.
- Flags update together with the low-half write of a legal op:
  - Non-MUL: `flag_z` = low word==0; `flag_n` = bit DATA_W-1; `flag_v` = 0.
  - MUL: `flag_z` = full 38-bit result==0; `flag_n` = bit 2*DATA_W-1; `flag_v` = high half != 0.
- Divide-by-zero arrives as 0 from the ALU and is written as 0 with `flag_z`=1.

## Timing
- Latency: `rf_we` asserts on the cycle after the transfer edge.
- A MUL high write follows exactly one cycle after its low write.
- Throughput: one non-MUL op per cycle; MUL occupies two write cycles.
- A new transfer is accepted during the WR_HI cycle, so writes are back-to-back with no bubble.
- Reset values: `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `flag_z`=0, `flag_n`=0, `flag_v`=0, `illegal_op`=0; state is IDLE.
- Reset mid-MUL (asserted in WR_LO or WR_HI): the pending high write is discarded and all outputs return to reset values immediately (asynchronous).
- `in_*` inputs are sampled only on a transfer edge; they are don't-care otherwise.

## Configuration
- `ALU_WB_FLAGS_EN`:
  - Defined: flag registers and the update logic above are built.
  - Undefined: `flag_z`, `flag_n` and `flag_v` are tied to constant 0 and no flag registers exist.
- Write datapath, handshake and `illegal_op` are identical in both builds.

## Test plan
- ADD result 38'h0_0001_2345, rd=2 → next cycle `rf_we`=1, addr 2, data 19'h12345; Z=0, N=0, V=0.
- MUL result {19'h00003, 19'h7FFFF}, rd=5 → cycle 1: addr 5, data 19'h7FFFF; cycle 2: addr 6, data 19'h00003; V=1; `in_ready`=0 during cycle 1.
- MUL with rd=7 and high half 19'h00001 → high write to addr 0 (wrap).
- Opcode 5'b01100 accepted → `rf_we` stays 0, `illegal_op` pulses once, flags hold their previous values.
- Three back-to-back SUB ops with `in_valid` held high → `rf_we` high for three consecutive cycles with matching addr/data; a SUB result of 0 gives Z=1.
- Reset asserted in the WR_LO cycle of a MUL → no high write occurs; all outputs are 0 and `in_ready`=1 on the first edge after release.
